// File: rtl/handshake_skid.sv
// Full register slice for a valid/ready stream: output register plus one skid word.
// Every handshake output comes from a flop, so neither timing direction passes through.
module handshake_skid #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_valid_i,
   input  logic [DATA_W-1:0] d_data_i,
   output logic              d_ready_o,
   output logic              s_valid_o,
   output logic [DATA_W-1:0] s_data_o,
   input  logic              s_ready_i,
   output logic [1:0]        level_o,
   output logic [CNT_W-1:0]  in_cnt_o,
   output logic [CNT_W-1:0]  out_cnt_o,
   output logic              proto_err_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] out_r;
   logic [DATA_W-1:0] skid_r;
   logic              stall_q;
   logic [DATA_W-1:0] stall_data_q;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = d_valid_i & d_ready_o;
   assign out_xfer = s_valid_o & s_ready_i;
   assign s_data_o = out_r;
   assign level_o  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= EMPTY;
         out_r        <= '0;
         skid_r       <= '0;
         s_valid_o    <= 1'b0;
         d_ready_o    <= 1'b0;
         in_cnt_o     <= '0;
         out_cnt_o    <= '0;
         proto_err_o  <= 1'b0;
         stall_q      <= 1'b0;
         stall_data_q <= '0;
      end else begin
         // Ready is 1 in every state but FULL; it only rises here after reset.
         d_ready_o <= 1'b1;
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_r     <= d_data_i;
                  s_valid_o <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  out_r <= d_data_i;
               end else if (in_xfer) begin
                  skid_r    <= d_data_i;
                  d_ready_o <= 1'b0;
                  state     <= FULL;
               end else if (out_xfer) begin
                  s_valid_o <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  out_r <= skid_r;
                  state <= BUSY;
               end else begin
                  d_ready_o <= 1'b0;
               end
            end
            default: begin
               s_valid_o <= 1'b0;
               state     <= EMPTY;
            end
         endcase

         if (in_xfer)  in_cnt_o  <= in_cnt_o + 1'b1;
         if (out_xfer) out_cnt_o <= out_cnt_o + 1'b1;

         // A word offered while not ready must be re-offered unchanged on the next edge.
         stall_q      <= d_valid_i & ~d_ready_o;
         stall_data_q <= d_data_i;
         if (stall_q && (!d_valid_i || d_data_i != stall_data_q))
            proto_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_handshake_skid.sv
// Directed and randomised checks of handshake_skid, including a 4-bit counter copy for wrap.
module tb_handshake_skid;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_valid_i;
   logic [7:0] d_data_i;
   logic       s_ready_i;

   logic        d_ready_o, s_valid_o, proto_err_o;
   logic [7:0]  s_data_o;
   logic [1:0]  level_o;
   logic [15:0] in_cnt_o, out_cnt_o;

   logic        d_ready_4, s_valid_4, proto_err_4;
   logic [7:0]  s_data_4;
   logic [1:0]  level_4;
   logic [3:0]  in_cnt_4, out_cnt_4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   handshake_skid #(.DATA_W(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .d_valid_i(d_valid_i), .d_data_i(d_data_i),
      .d_ready_o(d_ready_o), .s_valid_o(s_valid_o), .s_data_o(s_data_o),
      .s_ready_i(s_ready_i), .level_o(level_o), .in_cnt_o(in_cnt_o),
      .out_cnt_o(out_cnt_o), .proto_err_o(proto_err_o)
   );

   handshake_skid #(.DATA_W(8), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .d_valid_i(d_valid_i), .d_data_i(d_data_i),
      .d_ready_o(d_ready_4), .s_valid_o(s_valid_4), .s_data_o(s_data_4),
      .s_ready_i(s_ready_i), .level_o(level_4), .in_cnt_o(in_cnt_4),
      .out_cnt_o(out_cnt_4), .proto_err_o(proto_err_4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; d_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_w;
      logic       holding, in_x, out_x;
      int         sent, rcvd;

      // reset held 3 cycles with valid asserted
      rst = 1'b1; d_valid_i = 1'b1; d_data_i = 8'h77; s_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_svalid", s_valid_o, 0);
         chk("rst_dready", d_ready_o, 0);
         chk("rst_incnt", in_cnt_o, 0);
         chk("rst_level", level_o, 0);
      end
      chk("rst_sdata", s_data_o, 0);
      chk("rst_outcnt", out_cnt_o, 0);
      chk("rst_perr", proto_err_o, 0);
      rst = 1'b0; d_valid_i = 1'b0;
      chk("rel_dready_pre", d_ready_o, 0);
      tick();
      chk("rel_dready", d_ready_o, 1);
      chk("rel_level", level_o, 0);
      chk("rel_svalid", s_valid_o, 0);

      // back-to-back streaming
      s_ready_i = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         d_valid_i = 1'b1; d_data_i = 8'(i);
         tick();
         chk("str_svalid", s_valid_o, 1);
         chk("str_data", s_data_o, i);
         chk("str_level", level_o, 1);
         chk("str_dready", d_ready_o, 1);
      end
      d_valid_i = 1'b0;
      tick();
      chk("str_incnt", in_cnt_o, 16);
      chk("str_outcnt", out_cnt_o, 16);
      chk("str_level_end", level_o, 0);

      // backpressure fills the skid
      s_ready_i = 1'b0;
      d_valid_i = 1'b1; d_data_i = 8'hA1;
      tick();
      chk("bp_l1", level_o, 1);
      chk("bp_d1", s_data_o, 8'hA1);
      d_data_i = 8'hA2;
      tick();
      chk("bp_l2", level_o, 2);
      chk("bp_rdy0", d_ready_o, 0);
      chk("bp_hold", s_data_o, 8'hA1);
      d_valid_i = 1'b0;
      tick();
      chk("bp_hold2", s_data_o, 8'hA1);
      chk("bp_l2b", level_o, 2);
      s_ready_i = 1'b1;
      chk("bp_out1", s_data_o, 8'hA1);
      tick();
      chk("bp_out2", s_data_o, 8'hA2);
      chk("bp_rdy1", d_ready_o, 1);
      chk("bp_l1b", level_o, 1);
      tick();
      chk("bp_empty", s_valid_o, 0);
      chk("bp_incnt", in_cnt_o, 18);
      chk("bp_outcnt", out_cnt_o, 18);

      // protocol: legal hold, then a data change while stalled
      s_ready_i = 1'b0;
      d_valid_i = 1'b1; d_data_i = 8'hB1; tick();
      d_data_i = 8'hB2; tick();
      chk("pv_full", level_o, 2);
      d_data_i = 8'h55; tick();
      tick();
      chk("pv_legal", proto_err_o, 0);
      d_data_i = 8'h66; tick();
      chk("pv_err", proto_err_o, 1);
      chk("pv_data", s_data_o, 8'hB1);
      d_valid_i = 1'b0; tick(); tick();
      chk("pv_sticky", proto_err_o, 1);
      rst = 1'b1; tick();
      chk("pv_rst", proto_err_o, 0);
      rst = 1'b0; tick();
      chk("pv_rst_lvl", level_o, 0);

      // random valid/ready against a queue scoreboard
      do_reset();
      q.delete(); sent = 0; rcvd = 0; holding = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (!holding) begin
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
               d_valid_i = 1'b1; d_data_i = 8'($urandom);
            end else
               d_valid_i = 1'b0;
         end
         s_ready_i = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
         in_x  = d_valid_i & d_ready_o;
         out_x = s_valid_o & s_ready_i;
         if (out_x) begin
            exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
            chk("rnd_data", s_data_o, exp_w);
            rcvd++;
         end
         if (in_x) begin
            q.push_back(d_data_i);
            sent++;
         end
         holding = d_valid_i & ~in_x;
         tick();
         chk("rnd_inv", 16'(in_cnt_o - out_cnt_o), level_o);
         chk("rnd_level", level_o, q.size());
         if (rcvd == 1000) break;
      end
      d_valid_i = 1'b0;
      chk("rnd_count", rcvd, 1000);
      chk("rnd_perr", proto_err_o, 0);

      // 20 words ending FULL, then reset: 4-bit counters wrap
      do_reset();
      s_ready_i = 1'b1;
      for (int i = 0; i < 18; i++) begin
         d_valid_i = 1'b1; d_data_i = 8'(8'hC0 + i);
         tick();
      end
      d_valid_i = 1'b0; tick();
      s_ready_i = 1'b0;
      d_valid_i = 1'b1; d_data_i = 8'hD1; tick();
      d_data_i = 8'hD2; tick();
      d_valid_i = 1'b0;
      chk("wr_level", level_4, 2);
      chk("wr_in4", in_cnt_4, 4);
      chk("wr_out4", out_cnt_4, 2);
      chk("wr_in16", in_cnt_o, 20);
      rst = 1'b1; tick();
      rst = 1'b0; s_ready_i = 1'b1;
      chk("wr_rst_level", level_4, 0);
      chk("wr_rst_in4", in_cnt_4, 0);
      chk("wr_rst_out4", out_cnt_4, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_stale4", s_valid_4, 0);
         chk("wr_stale16", s_valid_o, 0);
         chk("wr_outcnt", out_cnt_o, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/handshake_skid.md
# handshake_skid

Full register slice for the single-clock valid/ready stream protocol. It accepts words from an upstream source and presents them to a downstream sink. `s_valid_o`, `s_data_o` and `d_ready_o` are all driven straight from flops, so no combinational path crosses the slice in either direction. It sits between pipeline stages where both the forward (valid/data) and backward (ready) timing paths must be broken, and sustains one transfer per cycle.

## Interface
- DATA_W, 8, width of the data word
- CNT_W, 16, width of the transfer counters (wrap-around)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- d_valid_i  input  1  upstream has a valid word
- d_data_i  input  DATA_W  upstream word
- d_ready_o  output  1  slice can accept a word (registered)
- s_valid_o  output  1  slice presents a valid word (registered)
- s_data_o  output  DATA_W  presented word (registered)
- s_ready_i  input  1  downstream accepts the presented word
- level_o  output  2  words held: 0, 1 or 2
- in_cnt_o  output  CNT_W  count of accepted upstream transfers
- out_cnt_o  output  CNT_W  count of completed downstream transfers
- proto_err_o  output  1  sticky upstream protocol violation

## Operation
- Transfer definitions:
  - Upstream transfer (IN): `d_valid_i & d_ready_o` at a rising edge.
  - Downstream transfer (OUT): `s_valid_o & s_ready_i` at a rising edge.
- Storage: output register `out_r` drives `s_data_o`; a skid register `skid_r` holds a second word.
- States:
  - EMPTY (level 0): `s_valid_o=0`, `d_ready_o=1`.
  - BUSY (level 1): `s_valid_o=1`, `d_ready_o=1`.
  - FULL (level 2): `s_valid_o=1`, `d_ready_o=0`.
- Transitions:
  - EMPTY: IN -> `out_r<=d_data_i`, go to BUSY. Otherwise stay.
  - BUSY: IN and OUT -> `out_r<=d_data_i`, stay in BUSY. IN only -> `skid_r<=d_data_i`, go to FULL. OUT only -> go to EMPTY. Neither -> stay.
  - FULL: IN is impossible. OUT -> `out_r<=skid_r`, go to BUSY. Otherwise hold.
- Ordering: words leave strictly in arrival order. No word is dropped or duplicated.
- `s_data_o` holds its last value when `s_valid_o=0`. It is don't-care for checking, but must not change while `s_valid_o=1` and `s_ready_i=0`.
- Counters:
  - `in_cnt_o` increments on every IN; `out_cnt_o` increments on every OUT.
  - Both wrap modulo 2^CNT_W.
  - Invariant: `in_cnt_o - out_cnt_o` (mod 2^CNT_W) equals `level_o`.
- Protocol check: if at edge N `d_valid_i=1` and `d_ready_o=0`, then at edge N+1 `d_valid_i` must still be 1 and `d_data_i` unchanged. A violation sets `proto_err_o=1` until `rst`. The slice's data behaviour is unaffected by the check.
- Reset mid-operation: any held words are discarded and the counters clear. No OUT is produced for the discarded words.

## Timing
- Reset values, held while `rst=1`:
  - `s_valid_o=0`, `s_data_o=0`, `level_o=0`, both counters 0, `proto_err_o=0`.
  - `d_ready_o=0`: no IN can occur during reset.
- `d_ready_o` becomes 1 after the first rising edge with `rst=0`.
- Latency: a word accepted at edge N appears on `s_data_o` with `s_valid_o=1` after edge N, when the slice is EMPTY or the word bypasses the skid. Through the skid, the latency is 1 cycle plus the downstream stall time.
- Throughput: one IN and one OUT per cycle in steady state, with `s_ready_i` held at 1.
- `d_ready_o` falls one edge after the IN that fills the skid. It rises one edge after the OUT that drains it.
- Simultaneous IN and OUT in BUSY keep `level_o=1` with no bubble.
- All outputs change only on rising edges of `clk`.

## Test plan
- Reset: hold `rst=1` for 3 cycles with `d_valid_i=1` -> `s_valid_o=0`, `d_ready_o=0`, counters 0. After release, `d_ready_o=1` one edge later and `level_o=0`.
- Streaming: `s_ready_i=1`, send 0x01..0x10 back-to-back -> `s_data_o` shows 0x01..0x10 one cycle after each IN. `level_o` stays 1, `in_cnt_o=out_cnt_o=16` at the end.
- Backpressure: with `s_ready_i=0`, send 0xA1 and 0xA2 -> `level_o=2`, `d_ready_o=0`, `s_data_o=0xA1` held. Raise `s_ready_i` -> 0xA1, then 0xA2 are delivered, and `d_ready_o` returns to 1 after the first OUT.
- Random valid/ready at 50% each over 1000 words -> output sequence equals input sequence, the counter invariant holds every cycle, and `proto_err_o=0`.
- Protocol violation: in FULL, hold `d_valid_i=1` with data 0x55, then change the data to 0x66 the next cycle -> `proto_err_o=1` and it remains set until `rst`.
- Mid-operation reset while FULL and with CNT_W=4 after 20 words (counters wrapped to 4) -> after reset, `level_o=0`, counters 0, and no stale word appears on `s_valid_o`.
